// File: rtl/hexled_display_ctrl.sv
// hexled_display_ctrl
//   Registered N-digit seven-segment display controller. Snapshots packed hex
//   digits on a load strobe and decodes each one to gfedcba segments. It also
//   provides leading-zero blanking, per-digit blink for set-mode editing, and
//   global 16-step PWM brightness dimming.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   load_i         snapshot strobe for digits_i
//   digits_i       packed nibbles, digit k = [4k+3:4k], digit 0 least significant
//   blank_lz_i     enable leading-zero blanking
//   blink_mask_i   bit k = 1 makes digit k blink
//   bright_i       brightness 0 (off) .. 15 (always on), sampled live
//   hex_o          registered segments, digit k = [7k+6:7k], bit 0 = segment a
//   blink_phase_o  current blink phase, 1 = visible half
module hexled_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic                      blank_lz_i,
  input  logic [NUM_DIGITS-1:0]     blink_mask_i,
  input  logic [3:0]                bright_i,
  output logic [7*NUM_DIGITS-1:0]   hex_o,
  output logic                      blink_phase_o
);

  localparam int             BCW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [6:0]     BLANK      = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Hex nibble to active-high gfedcba pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Map an active-high pattern onto the board's pin polarity.
  function automatic logic [6:0] apply_polarity(input logic [6:0] seg);
    return (ACTIVE_LOW != 0) ? ~seg : seg;
  endfunction

  // ---- stage p0: digit snapshot, blink and PWM counters ----
  logic [4*NUM_DIGITS-1:0] digit_p0;
  logic [BCW-1:0]          blink_cnt_p0;
  logic                    blink_phase_p0;
  logic [3:0]              pwm_cnt_p0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_p0 <= '0;
    end else if (load_i) begin
      digit_p0 <= digits_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_p0   <= '0;
      blink_phase_p0 <= 1'b1;
    end else if (blink_cnt_p0 == BLINK_LAST) begin
      blink_cnt_p0   <= '0;
      blink_phase_p0 <= ~blink_phase_p0;
    end else begin
      blink_cnt_p0   <= blink_cnt_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_cnt_p0 <= '0;
    end else begin
      pwm_cnt_p0 <= pwm_cnt_p0 + 4'd1;
    end
  end

  // Combinational segment selection ahead of the output register.
  logic [NUM_DIGITS:0]     zero_above;
  logic                    pwm_on;
  logic [7*NUM_DIGITS-1:0] hex_next;

  always_comb begin
    zero_above             = '0;
    zero_above[NUM_DIGITS] = 1'b1;
    // zero_above[k] is set when digit k and every digit above it hold 0.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (digit_p0[4*k +: 4] == 4'h0);
    end
  end

  always_comb begin
    pwm_on = (bright_i == 4'hF) || (pwm_cnt_p0 < bright_i);
  end

  always_comb begin
    hex_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!pwm_on) begin
        hex_next[7*k +: 7] = BLANK;
      end else if (!blink_phase_p0 && blink_mask_i[k]) begin
        hex_next[7*k +: 7] = BLANK;
      end else if (blank_lz_i && (k >= 1) && zero_above[k]) begin
        hex_next[7*k +: 7] = BLANK;
      end else begin
        hex_next[7*k +: 7] = apply_polarity(seg_decode(digit_p0[4*k +: 4]));
      end
    end
  end

  // ---- stage p1: registered segment outputs ----
  logic [7*NUM_DIGITS-1:0] hex_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hex_p1 <= {NUM_DIGITS{BLANK}};
    end else begin
      hex_p1 <= hex_next;
    end
  end

  assign hex_o         = hex_p1;
  assign blink_phase_o = blink_phase_p0;

endmodule
